reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
- Parametrised successor to the fixed 8x16 register file of the multicycle RISC datapath.
- Width and depth are set by parameters; two combinational read ports and one active-low write port.
- Adds a bulk-clear sequencer that zeroes all registers, one per cycle, under a start/busy handshake.
- Instantiated by the datapath in place of the fixed-size file; the controller FSM drives the clear at program load.

Parameters:
- WIDTH, 16, data bits per register.
- NREG, 8, number of registers; power of two, minimum 2.
- AW, $clog2(NREG), address width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- readAdd1  input  AW  read port 1 address.
- readAdd2  input  AW  read port 2 address.
- out1  output  WIDTH  read port 1 data.
- out2  output  WIDTH  read port 2 data.
- write  input  1  write strobe, active-low (0 = write).
- write_select  input  AW  write address.
- in  input  WIDTH  write data.
- clr_start  input  1  one-cycle pulse that requests a bulk clear.
- clr_busy  output  1  high while the clear sequencer runs.
- clr_done  output  1  one-cycle pulse after the last register is cleared.

Behaviour:
- Reset (asynchronous, active-low):
  - All registers are set to 0 and the FSM goes to IDLE.
  - clr_busy = 0, clr_done = 0.
  - out1 and out2 therefore read 0.
- Reads:
  - out1 = reg[readAdd1] and out2 = reg[readAdd2], combinational, zero latency.
  - Both ports may address the same register.
- Write:
  - If write == 0 on a rising clk edge and the FSM is in IDLE, then reg[write_select] <= in.
  - The new value is visible on a read port in the cycle after the edge.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: on clr_start = 1 at an edge, go to CLEAR with clr_ptr = 0 and clr_busy = 1.
  - CLEAR: each edge does reg[clr_ptr] <= 0 and clr_ptr++. At clr_ptr == NREG-1, clear that register and go to DONE. The clear takes exactly NREG cycles.
  - DONE: clr_done = 1 and clr_busy = 0 for one cycle, then IDLE.
  - clr_busy and clr_done are registered outputs.
- Simultaneous events:
  - Write and clr_start on the same edge in IDLE: the write is performed, and CLEAR is entered on the same edge.
  - Writes while in CLEAR or DONE are ignored (dropped, not queued). The controller must hold writes off until clr_done.
  - clr_start while in CLEAR or DONE is ignored; a clear does not restart.
- Reads during CLEAR return current contents: registers below clr_ptr read 0, the rest read their old values.
- Reset asserted mid-clear: all registers are zeroed immediately, the FSM goes to IDLE, and no clr_done is issued.
- Out-of-range addresses cannot occur because NREG is a power of two.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - When write == 0, the FSM is in IDLE, and readAddN == write_select, outN = in in the same cycle (write-through forwarding).
  - Forwarding is applied to each port independently.
  - There is no bypass during CLEAR.
- Undefined: reads always return stored contents; the new value is visible the next cycle.

Decomposition:
- Shared package reg_file_pkg holds:
  - clr_state_t enum {IDLE, CLEAR, DONE};
  - the default WIDTH and NREG constants;
  - the localparam WRITE_ACTIVE = 1'b0, which documents the strobe polarity.
- One sub-module, reg_clear_seq, holds the FSM, clr_ptr, clr_busy, clr_done and a write-inhibit output.
- Storage and read muxing stay in reg_file_param.

Test Plan:
- Reset:
  - Release reset, then read all addresses -> every value is 0x0000.
  - clr_busy = 0, clr_done = 0.
- Write/read-back:
  - Write 0x000C to R1 and 0x000A to R3 (write = 0 for one edge each).
  - Next cycle, readAdd1 = 1 and readAdd2 = 3 -> out1 = 0x000C, out2 = 0x000A.
- Inactive strobe:
  - Hold write = 1 with in = 0xFFFF and write_select = 5 for 4 cycles -> R5 stays 0x0000.
- Bulk clear:
  - Preload R0..R7 = 0x1111..0x8888, then pulse clr_start.
  - clr_busy is high for exactly 8 cycles, then clr_done pulses once.
  - All registers read 0.
  - A write to R2 of 0x00FF issued in cycle 3 of the clear is dropped, and R2 reads 0.
- Reset mid-clear:
  - Assert reset in cycle 4 of the clear -> all registers read 0 and clr_busy drops asynchronously.
  - No clr_done pulse follows.
- Bypass (REG_FILE_BYPASS_EN defined):
  - Write 0x0ABC to R6 with readAdd1 = 6 -> out1 = 0x0ABC in the same cycle.
  - With the macro undefined -> out1 shows the old value until the next cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and constants for the parametrised register file
package reg_file_pkg;

  // Default geometry of the register file (matches the fixed 8x16 original).
  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_NREG  = 8;

  // The write strobe is active-low: a 0 on write requests a store.
  localparam logic WRITE_ACTIVE = 1'b0;

  // Bulk-clear sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/reg_file_param_if.sv
// rtl/reg_file_param_if.sv - read/write/clear bus between the controller and the register file
interface reg_file_param_if #(
  parameter int WIDTH = reg_file_pkg::DEFAULT_WIDTH,
  parameter int NREG  = reg_file_pkg::DEFAULT_NREG
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]    readAdd1;
  logic [AW-1:0]    readAdd2;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             write;
  logic [AW-1:0]    write_select;
  logic [WIDTH-1:0] in;
  logic             clr_start;
  logic             clr_busy;
  logic             clr_done;

  // Controller side: issues addresses, writes and clear requests.
  modport master (
    output readAdd1, readAdd2, write, write_select, in, clr_start,
    input  out1, out2, clr_busy, clr_done
  );

  // Register file side.
  modport slave (
    input  readAdd1, readAdd2, write, write_select, in, clr_start,
    output out1, out2, clr_busy, clr_done
  );

endinterface

// File: rtl/reg_clear_seq.sv
// rtl/reg_clear_seq.sv - bulk-clear FSM that walks every register once and reports busy/done
module reg_clear_seq
  import reg_file_pkg::*;
#(
  parameter int NREG = DEFAULT_NREG
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_start_i,
  output logic                    clr_busy_o,
  output logic                    clr_done_o,
  output logic                    clr_en_o,
  output logic [$clog2(NREG)-1:0] clr_ptr_o,
  output logic                    wr_inhibit_o
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] LAST_PTR = AW'(NREG - 1);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;

  // State, pointer and the registered handshake outputs; reset aborts any clear silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      clr_ptr_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Next state: start only from IDLE, one register per cycle in CLEAR, single-cycle DONE.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start_i) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = DONE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + AW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        clr_ptr_d = '0;
      end
    endcase
    // Outputs are registered, so they are derived from where the FSM is heading.
    clr_busy_d = (state_d == CLEAR);
    clr_done_d = (state_d == DONE);
  end

  assign clr_busy_o   = clr_busy_q;
  assign clr_done_o   = clr_done_q;
  assign clr_en_o     = (state_q == CLEAR);
  assign clr_ptr_o    = clr_ptr_q;
  // Writes are only honoured in IDLE; anything arriving in CLEAR or DONE is dropped.
  assign wr_inhibit_o = (state_q != IDLE);

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 2R/1W register file with bulk clear; REG_FILE_BYPASS_EN enables write-through reads
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREG  = DEFAULT_NREG
) (
  input  logic             clk,
  input  logic             reset,
  reg_file_param_if.slave  bus
);
  // NREG must be a power of two (>= 2), so every address is in range.
  localparam int AW = $clog2(NREG);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  logic             clr_en;
  logic [AW-1:0]    clr_ptr;
  logic             wr_inhibit;
  logic             clr_busy;
  logic             clr_done;
  logic             wr_en;
  logic [WIDTH-1:0] rd1_data;
  logic [WIDTH-1:0] rd2_data;

  reg_clear_seq #(
    .NREG (NREG)
  ) u_clear_seq (
    .clk          (clk),
    .reset        (reset),
    .clr_start_i  (bus.clr_start),
    .clr_busy_o   (clr_busy),
    .clr_done_o   (clr_done),
    .clr_en_o     (clr_en),
    .clr_ptr_o    (clr_ptr),
    .wr_inhibit_o (wr_inhibit)
  );

  assign wr_en = (bus.write == WRITE_ACTIVE) && !wr_inhibit;

  // Next register contents: the sequencer's clear and a host write never coincide.
  always_comb begin
    regs_d = regs_q;
    if (clr_en) begin
      regs_d[clr_ptr] = '0;
    end else if (wr_en) begin
      regs_d[bus.write_select] = bus.in;
    end
  end

  // Storage; reset zeroes every register immediately, even mid-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports, optionally forwarding the write data being stored this cycle.
  always_comb begin
    rd1_data = regs_q[bus.readAdd1];
    rd2_data = regs_q[bus.readAdd2];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && (bus.readAdd1 == bus.write_select)) rd1_data = bus.in;
    if (wr_en && (bus.readAdd2 == bus.write_select)) rd2_data = bus.in;
`endif
  end

  assign bus.out1     = rd1_data;
  assign bus.out2     = rd2_data;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - scoreboard bench for reg_file_param
module tb_reg_file_param;
  localparam int W = 16;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] exp_q [$];
  logic         exp_bit_q [$];
  logic [W-1:0] model [N];

  reg_file_param_if #(.WIDTH(W), .NREG(N)) bus ();

  reg_file_param #(.WIDTH(W), .NREG(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.write = 1'b0;
    bus.write_select = a;
    bus.in = d;
    @(negedge clk);
    bus.write = 1'b1;
    model[a] = d;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    bus.readAdd1 = '0; bus.readAdd2 = '0; bus.write = 1'b1;
    bus.write_select = '0; bus.in = '0; bus.clr_start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a < N; a++) model[a] = '0;
    for (int a = 0; a < N; a++) begin
      exp_q.push_back(model[a]);
      exp_q.push_back(model[N-1-a]);
    end
    for (int a = 0; a < N; a++) begin
      @(negedge clk);
      bus.readAdd1 = 3'(a);
      bus.readAdd2 = 3'(N - 1 - a);
      #1;
      e = exp_q.pop_front(); checks++;
      if (bus.out1 !== e) begin errors++; $display("FAIL reset_out1[%0d] got %h exp %h", a, bus.out1, e); end
      e = exp_q.pop_front(); checks++;
      if (bus.out2 !== e) begin errors++; $display("FAIL reset_out2[%0d] got %h exp %h", a, bus.out2, e); end
    end
    checks++;
    if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.clr_busy); end
    checks++;
    if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.clr_done); end
  endtask

  task automatic test_write_read();
    logic [W-1:0] e;
    do_write(3'd1, 16'h000C);
    do_write(3'd3, 16'h000A);
    exp_q.push_back(model[1]);
    exp_q.push_back(model[3]);
    bus.readAdd1 = 3'd1;
    bus.readAdd2 = 3'd3;
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.out1 !== e) begin errors++; $display("FAIL wr_rd_out1 got %h exp %h", bus.out1, e); end
    e = exp_q.pop_front(); checks++;
    if (bus.out2 !== e) begin errors++; $display("FAIL wr_rd_out2 got %h exp %h", bus.out2, e); end
  endtask

  task automatic test_inactive_strobe();
    logic [W-1:0] e;
    @(negedge clk);
    bus.write = 1'b1; bus.write_select = 3'd5; bus.in = 16'hFFFF;
    repeat (4) @(negedge clk);
    exp_q.push_back(model[5]);
    bus.readAdd1 = 3'd5;
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.out1 !== e) begin errors++; $display("FAIL inactive_strobe got %h exp %h", bus.out1, e); end
    bus.in = '0;
  endtask

  task automatic test_bulk_clear();
    logic [W-1:0] e;
    logic         eb;
    for (int i = 0; i < N; i++) do_write(3'(i), 16'(16'h1111 * (i + 1)));
    @(negedge clk);
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) @(negedge clk);
      bus.write = 1'b1;
      bus.clr_start = 1'b0;
      if (c == 3) begin bus.write = 1'b0; bus.write_select = 3'd2; bus.in = 16'h00FF; end
      if (c == 4) begin bus.write = 1'b0; bus.write_select = 3'd0; bus.in = 16'h00FF; end
      if (c == 5) bus.clr_start = 1'b1;
      if (c == 9) begin bus.write = 1'b0; bus.write_select = 3'd4; bus.in = 16'h0044; end
      exp_bit_q.push_back(c <= 8);
      exp_bit_q.push_back(c == 9);
      #1;
      eb = exp_bit_q.pop_front(); checks++;
      if (bus.clr_busy !== eb) begin errors++; $display("FAIL clear_busy c=%0d got %b exp %b", c, bus.clr_busy, eb); end
      eb = exp_bit_q.pop_front(); checks++;
      if (bus.clr_done !== eb) begin errors++; $display("FAIL clear_done c=%0d got %b exp %b", c, bus.clr_done, eb); end
      if (c == 5) begin
        // R0..R3 already cleared, R4 not yet
        exp_q.push_back(16'h0000);
        exp_q.push_back(model[4]);
        bus.readAdd1 = 3'd3;
        bus.readAdd2 = 3'd4;
        #1;
        e = exp_q.pop_front(); checks++;
        if (bus.out1 !== e) begin errors++; $display("FAIL mid_clear_r3 got %h exp %h", bus.out1, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.out2 !== e) begin errors++; $display("FAIL mid_clear_r4 got %h exp %h", bus.out2, e); end
      end
    end
    bus.write = 1'b1;
    bus.clr_start = 1'b0;
    for (int a = 0; a < N; a++) model[a] = '0;
    for (int a = 0; a < N; a++) exp_q.push_back(model[a]);
    for (int a = 0; a < N; a++) begin
      @(negedge clk);
      bus.readAdd1 = 3'(a);
      #1;
      e = exp_q.pop_front(); checks++;
      if (bus.out1 !== e) begin errors++; $display("FAIL after_clear[%0d] got %h exp %h", a, bus.out1, e); end
    end
  endtask

  task automatic test_write_with_start();
    logic [W-1:0] e;
    int done_cnt;
    @(negedge clk);
    bus.write = 1'b0; bus.write_select = 3'd2; bus.in = 16'h2222;
    bus.clr_start = 1'b1; bus.readAdd1 = 3'd2;
    @(negedge clk);
    bus.write = 1'b1; bus.clr_start = 1'b0;
    exp_q.push_back(16'h2222);
    #1;
    checks++;
    if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL wr_start_busy got %b exp 1", bus.clr_busy); end
    e = exp_q.pop_front(); checks++;
    if (bus.out1 !== e) begin errors++; $display("FAIL wr_start_data got %h exp %h", bus.out1, e); end
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.clr_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL wr_start_done_count got %0d exp 1", done_cnt); end
    for (int a = 0; a < N; a++) model[a] = '0;
  endtask

  task automatic test_reset_mid_clear();
    logic [W-1:0] e;
    int done_cnt;
    do_write(3'd5, 16'h5555);
    do_write(3'd7, 16'h7777);
    @(negedge clk);
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.clr_busy); end
    for (int a = 0; a < N; a++) model[a] = '0;
    for (int a = 0; a < N; a++) exp_q.push_back(model[a]);
    for (int a = 0; a < N; a++) begin
      bus.readAdd1 = 3'(a);
      #1;
      e = exp_q.pop_front(); checks++;
      if (bus.out1 !== e) begin errors++; $display("FAIL midrst_reg[%0d] got %h exp %h", a, bus.out1, e); end
    end
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.clr_done !== 1'b0) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL midrst_done_count got %0d exp 0", done_cnt); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] e;
    @(negedge clk);
    bus.write = 1'b0; bus.write_select = 3'd6; bus.in = 16'h0ABC;
    bus.readAdd1 = 3'd6; bus.readAdd2 = 3'd5;
`ifdef REG_FILE_BYPASS_EN
    exp_q.push_back(16'h0ABC);
`else
    exp_q.push_back(model[6]);
`endif
    exp_q.push_back(model[5]);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.out1 !== e) begin errors++; $display("FAIL bypass_same_cycle got %h exp %h", bus.out1, e); end
    e = exp_q.pop_front(); checks++;
    if (bus.out2 !== e) begin errors++; $display("FAIL bypass_other_port got %h exp %h", bus.out2, e); end
    @(negedge clk);
    bus.write = 1'b1;
    model[6] = 16'h0ABC;
    exp_q.push_back(model[6]);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.out1 !== e) begin errors++; $display("FAIL bypass_next_cycle got %h exp %h", bus.out1, e); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_inactive_strobe();
    test_bulk_clear();
    test_write_with_start();
    test_reset_mid_clear();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
